// File: rtl/i2c_slave_regfile.sv
// I2C target at a fixed 7-bit address fronting a small byte register file.
// Define I2C_SLAVE_AUTO_INC_EN to advance the pointer after each written or ACKed read byte.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1100110,
    parameter int         MEM_DEPTH  = 16,
    localparam int        PTR_W      = $clog2(MEM_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SCL,
    inout  wire              SDA,
    input  logic [PTR_W-1:0] dbg_addr,
    output logic [7:0]       dbg_data,
    output logic             wr_valid,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy,
    output logic             rd_nack
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WRITE, ST_WR_ACK, ST_READ, ST_RD_ACK, ST_WAIT_STOP
    } state_t;

    state_t           state_reg, state_next;
    logic             scl_sync1_reg, scl_sync2_reg, scl_prev_reg;
    logic             sda_sync1_reg, sda_sync2_reg, sda_prev_reg;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [6:0]       shift_reg, shift_next;
    logic [6:0]       tx_shift_reg, tx_shift_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next, ptr_step;
    logic             sda_low_reg, sda_low_next;
    logic             busy_reg, busy_next;
    logic             wr_valid_reg, wr_valid_next;
    logic [PTR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [7:0]       wr_data_reg, wr_data_next;
    logic             rd_nack_reg, rd_nack_next;
    logic             mem_we;
    logic [7:0]       mem [MEM_DEPTH];

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    assign scl_rise  = scl_sync2_reg & ~scl_prev_reg;
    assign scl_fall  = ~scl_sync2_reg & scl_prev_reg;
    assign start_det = scl_sync2_reg & scl_prev_reg & sda_prev_reg & ~sda_sync2_reg;
    assign stop_det  = scl_sync2_reg & scl_prev_reg & ~sda_prev_reg & sda_sync2_reg;
    assign rx_byte   = {shift_reg, sda_sync2_reg};

`ifdef I2C_SLAVE_AUTO_INC_EN
    assign ptr_step = ptr_reg + PTR_W'(1);
`else
    assign ptr_step = ptr_reg;
`endif

    // Open-drain: only ever pull low
    assign SDA      = sda_low_reg ? 1'b0 : 1'bz;
    assign dbg_data = mem[dbg_addr];
    assign wr_valid = wr_valid_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign busy     = busy_reg;
    assign rd_nack  = rd_nack_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            {scl_sync1_reg, scl_sync2_reg, scl_prev_reg} <= 3'b111;
            {sda_sync1_reg, sda_sync2_reg, sda_prev_reg} <= 3'b111;
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            tx_shift_reg <= '0;
            ptr_reg      <= '0;
            sda_low_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            wr_valid_reg <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            rd_nack_reg  <= 1'b0;
        end else begin
            {scl_sync1_reg, scl_sync2_reg, scl_prev_reg} <= {SCL, scl_sync1_reg, scl_sync2_reg};
            {sda_sync1_reg, sda_sync2_reg, sda_prev_reg} <= {SDA, sda_sync1_reg, sda_sync2_reg};
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            tx_shift_reg <= tx_shift_next;
            ptr_reg      <= ptr_next;
            sda_low_reg  <= sda_low_next;
            busy_reg     <= busy_next;
            wr_valid_reg <= wr_valid_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            rd_nack_reg  <= rd_nack_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[ptr_reg] <= rx_byte;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        tx_shift_next = tx_shift_reg;
        ptr_next      = ptr_reg;
        sda_low_next  = sda_low_reg;
        busy_next     = busy_reg;
        wr_valid_next = 1'b0;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;
        rd_nack_next  = 1'b0;
        mem_we        = 1'b0;
        if (start_det) begin
            state_next   = ST_ADDR;
            bit_cnt_next = '0;
            sda_low_next = 1'b0;
            busy_next    = 1'b0;
        end else if (stop_det) begin
            state_next   = ST_IDLE;
            sda_low_next = 1'b0;
            busy_next    = 1'b0;
        end else begin
            case (state_reg)
                ST_ADDR, ST_PTR, ST_WRITE: if (scl_rise) begin
                    shift_next   = rx_byte[6:0];
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd7) begin
                        if (state_reg == ST_ADDR) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state_next = ST_ADDR_ACK;
                                busy_next  = 1'b1;
                            end else begin
                                state_next = ST_WAIT_STOP;
                            end
                        end else if (state_reg == ST_PTR) begin
                            ptr_next   = rx_byte[PTR_W-1:0];
                            state_next = ST_PTR_ACK;
                        end else begin
                            mem_we        = 1'b1;
                            wr_valid_next = 1'b1;
                            wr_addr_next  = ptr_reg;
                            wr_data_next  = rx_byte;
                            ptr_next      = ptr_step;
                            state_next    = ST_WR_ACK;
                        end
                    end
                end
                // bit_cnt 8: drive ACK on the 8th fall; 9: release on the 9th fall
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: if (scl_fall) begin
                    if (bit_cnt_reg == 4'd8) begin
                        sda_low_next = 1'b1;
                        bit_cnt_next = 4'd9;
                    end else begin
                        bit_cnt_next = '0;
                        sda_low_next = 1'b0;
                        if (state_reg == ST_ADDR_ACK && shift_reg[0]) begin
                            tx_shift_next = mem[ptr_reg][6:0];
                            sda_low_next  = ~mem[ptr_reg][7];
                            state_next    = ST_READ;
                        end else if (state_reg == ST_ADDR_ACK) begin
                            state_next = ST_PTR;
                        end else begin
                            state_next = ST_WRITE;
                        end
                    end
                end
                ST_READ: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            sda_low_next = 1'b0;
                            state_next   = ST_RD_ACK;
                        end else begin
                            sda_low_next  = ~tx_shift_reg[6];
                            tx_shift_next = {tx_shift_reg[5:0], 1'b0};
                        end
                    end
                end
                // Master's ACK is sampled on the rise; next byte goes out on the following fall
                ST_RD_ACK: begin
                    if (scl_rise && bit_cnt_reg == 4'd8) begin
                        if (sda_sync2_reg) begin
                            rd_nack_next = 1'b1;
                            state_next   = ST_WAIT_STOP;
                        end else begin
                            ptr_next     = ptr_step;
                            bit_cnt_next = 4'd9;
                        end
                    end else if (scl_fall && bit_cnt_reg == 4'd9) begin
                        tx_shift_next = mem[ptr_reg][6:0];
                        sda_low_next  = ~mem[ptr_reg][7];
                        bit_cnt_next  = '0;
                        state_next    = ST_READ;
                    end
                end
                default: sda_low_next = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: an open-drain bus master drives write/read transfers.
module tb_i2c_slave_regfile;
`ifdef I2C_SLAVE_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [3:0] dbg_addr = '0;
    wire        sda_bus;
    logic [7:0] dbg_data;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       rd_nack;

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave_regfile dut (
        .clk(clk), .reset(reset), .SCL(scl), .SDA(sda_bus),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .rd_nack(rd_nack)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_mem [16];
    int         exp_ptr = 0;
    int         wr_cnt = 0;
    int         nack_cnt = 0;
    logic [3:0] wr_addr_log [$];
    logic [7:0] wr_data_log [$];

    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            wr_addr_log.push_back(wr_addr);
            wr_data_log.push_back(wr_data);
        end
        if (rd_nack) nack_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1, "timeout");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        wait_clks(4); m_low = ~b;
        wait_clks(4); scl = 1'b1;
        wait_clks(8); scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wait_clks(4); m_low = 1'b0;
        wait_clks(4); scl = 1'b1;
        wait_clks(4); b = sda_bus;
        wait_clks(4); scl = 1'b0;
    endtask

    task automatic i2c_start();
        m_low = 1'b0;
        wait_clks(8); scl = 1'b1;
        wait_clks(8); m_low = 1'b1;
        wait_clks(8); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clks(4); m_low = 1'b1;
        wait_clks(4); scl = 1'b1;
        wait_clks(8); m_low = 1'b0;
        wait_clks(8);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
        $display("  master wrote 0x%02h, target ack bit %0b", d, ack);
    endtask

    task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) recv_bit(d[i]);
        send_bit(ack_bit);
        m_low = 1'b0;
        $display("  master read 0x%02h, sent ack bit %0b", d, ack_bit);
    endtask

    task automatic model_write(input logic [7:0] d);
        exp_mem[exp_ptr] = d;
        if (AUTO_INC) exp_ptr = (exp_ptr + 1) % 16;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        reset = 1'b1;
        wait_clks(5);
        vectors++; if (sda_bus !== 1'b1) begin miscompares++; $display("FAIL reset_sda: got %b want 1", sda_bus); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (wr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
        vectors++; if (rd_nack !== 1'b0) begin miscompares++; $display("FAIL reset_rd_nack: got %b want 0", rd_nack); end
        vectors++; if (wr_addr !== 4'h0) begin miscompares++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
        vectors++; if (wr_data !== 8'h00) begin miscompares++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
        vectors++; if (dbg_data !== 8'h00) begin miscompares++; $display("FAIL reset_dbg_data: got %h want 00", dbg_data); end
        reset = 1'b0;
        wait_clks(5);
    endtask

    task automatic test_write();
        logic       ack;
        int         base;
        logic [7:0] bytes [5];
        bytes = '{8'hCC, 8'h04, 8'h01, 8'h02, 8'h04};
        base = wr_cnt;
        $display("test_write: addr 0xCC ptr 0x04 data 01 02 04");
        i2c_start();
        for (int k = 0; k < 5; k++) begin
            send_byte(bytes[k], ack);
            vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL write_ack%0d: got %b want 0", k, ack); end
            if (k == 0) begin
                vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL write_busy: got %b want 1", busy); end
            end
            if (k == 1) exp_ptr = 4;
            if (k >= 2) model_write(bytes[k]);
        end
        i2c_stop();
        vectors++; if (wr_cnt - base !== 3) begin miscompares++; $display("FAIL write_pulses: got %0d want 3", wr_cnt - base); end
        for (int k = 0; k < 3 && base + k < wr_cnt; k++) begin
            vectors++;
            if (wr_addr_log[base+k] !== (AUTO_INC ? 4'(4 + k) : 4'd4) || wr_data_log[base+k] !== bytes[k+2]) begin
                miscompares++;
                $display("FAIL write_log%0d: got %h/%h want %h/%h", k, wr_addr_log[base+k], wr_data_log[base+k],
                         AUTO_INC ? 4'(4 + k) : 4'd4, bytes[k+2]);
            end
        end
        for (int a = 4; a < 7; a++) begin
            dbg_addr = 4'(a); wait_clks(1);
            vectors++; if (dbg_data !== exp_mem[a]) begin miscompares++; $display("FAIL write_mem%0d: got %h want %h", a, dbg_data, exp_mem[a]); end
        end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] d;
        int         nbase;
        nbase = nack_cnt;
        $display("test_read: ptr 0x04, repeated START, read 3 bytes");
        i2c_start();
        send_byte(8'hCC, ack);
        send_byte(8'h04, ack);
        exp_ptr = 4;
        i2c_start();
        send_byte(8'hCD, ack);
        vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL read_addr_ack: got %b want 0", ack); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL read_busy: got %b want 1", busy); end
        for (int k = 0; k < 3; k++) begin
            recv_byte(k == 2, d);
            vectors++; if (d !== exp_mem[exp_ptr]) begin miscompares++; $display("FAIL read_byte%0d: got %h want %h", k, d, exp_mem[exp_ptr]); end
            if (k < 2 && AUTO_INC) exp_ptr++;
        end
        vectors++; if (nack_cnt - nbase !== 1) begin miscompares++; $display("FAIL read_nack_pulses: got %0d want 1", nack_cnt - nbase); end
        i2c_stop();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL read_busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_bad_addr();
        logic ack;
        int   base;
        base = wr_cnt;
        $display("test_bad_addr: addr 0xA0 then 0x55");
        i2c_start();
        send_byte(8'hA0, ack);
        vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL badaddr_ack: got %b want 1", ack); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL badaddr_busy: got %b want 0", busy); end
        send_byte(8'h55, ack);
        vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL badaddr_data_ack: got %b want 1", ack); end
        i2c_stop();
        vectors++; if (wr_cnt !== base) begin miscompares++; $display("FAIL badaddr_wr_valid: got %0d want %0d", wr_cnt, base); end
        dbg_addr = 4'd4; wait_clks(1);
        vectors++; if (dbg_data !== exp_mem[4]) begin miscompares++; $display("FAIL badaddr_mem4: got %h want %h", dbg_data, exp_mem[4]); end
    endtask

    task automatic test_wrap();
        logic       ack;
        logic [7:0] want15, want0;
        want15 = AUTO_INC ? 8'hAA : 8'hBB;
        want0  = AUTO_INC ? 8'hBB : 8'h00;
        $display("test_wrap: ptr 0x0F data AA BB");
        i2c_start();
        send_byte(8'hCC, ack);
        send_byte(8'h0F, ack);
        exp_ptr = 15;
        send_byte(8'hAA, ack); model_write(8'hAA);
        send_byte(8'hBB, ack); model_write(8'hBB);
        i2c_stop();
        dbg_addr = 4'd15; wait_clks(1);
        vectors++; if (dbg_data !== want15) begin miscompares++; $display("FAIL wrap_mem15: got %h want %h", dbg_data, want15); end
        dbg_addr = 4'd0; wait_clks(1);
        vectors++; if (dbg_data !== want0) begin miscompares++; $display("FAIL wrap_mem0: got %h want %h", dbg_data, want0); end
    endtask

    task automatic test_partial();
        logic       ack;
        logic [7:0] d;
        int         base;
        base = wr_cnt;
        $display("test_partial: ptr 0x04, 4 data bits, STOP");
        i2c_start();
        send_byte(8'hCC, ack);
        send_byte(8'h04, ack);
        exp_ptr = 4;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_stop();
        vectors++; if (sda_bus !== 1'b1) begin miscompares++; $display("FAIL partial_sda: got %b want 1", sda_bus); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL partial_busy: got %b want 0", busy); end
        vectors++; if (wr_cnt !== base) begin miscompares++; $display("FAIL partial_wr_valid: got %0d want %0d", wr_cnt, base); end
        dbg_addr = 4'd4; wait_clks(1);
        vectors++; if (dbg_data !== exp_mem[4]) begin miscompares++; $display("FAIL partial_mem4: got %h want %h", dbg_data, exp_mem[4]); end
        i2c_start();
        send_byte(8'hCD, ack);
        recv_byte(1'b1, d);
        vectors++; if (d !== exp_mem[4]) begin miscompares++; $display("FAIL partial_ptr_read: got %h want %h", d, exp_mem[4]); end
        i2c_stop();
    endtask

    task automatic test_reset_mid();
        logic       ack;
        logic       b;
        logic [7:0] d;
        $display("test_reset_mid: read 0xFE from ptr 7, reset at bit 0");
        i2c_start();
        send_byte(8'hCC, ack);
        send_byte(8'h07, ack);
        send_byte(8'hFE, ack);
        i2c_start();
        send_byte(8'hCC, ack);
        send_byte(8'h07, ack);
        i2c_start();
        send_byte(8'hCD, ack);
        for (int i = 7; i >= 1; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        vectors++; if (d[7:1] !== 7'h7F) begin miscompares++; $display("FAIL mid_bits: got %h want 7f", d[7:1]); end
        wait_clks(6);
        vectors++; if (sda_bus !== 1'b0) begin miscompares++; $display("FAIL mid_bit0_driven: got %b want 0", sda_bus); end
        reset = 1'b1;
        wait_clks(1);
        vectors++; if (sda_bus !== 1'b1) begin miscompares++; $display("FAIL mid_sda_release: got %b want 1", sda_bus); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
        vectors++; if (wr_addr !== 4'h0 || wr_data !== 8'h00) begin miscompares++; $display("FAIL mid_wr_regs: got %h/%h want 0/00", wr_addr, wr_data); end
        vectors++; if (wr_valid !== 1'b0 || rd_nack !== 1'b0) begin miscompares++; $display("FAIL mid_pulses: got %b/%b want 0/0", wr_valid, rd_nack); end
        dbg_addr = 4'd7; wait_clks(1);
        vectors++; if (dbg_data !== 8'h00) begin miscompares++; $display("FAIL mid_mem_clear: got %h want 00", dbg_data); end
        reset = 1'b0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        exp_ptr = 0;
        i2c_stop();
        i2c_start();
        send_byte(8'hCC, ack);
        send_byte(8'h03, ack);
        send_byte(8'h77, ack);
        vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL mid_resume_ack: got %b want 0", ack); end
        i2c_stop();
        dbg_addr = 4'd3; wait_clks(1);
        vectors++; if (dbg_data !== 8'h77) begin miscompares++; $display("FAIL mid_resume_mem3: got %h want 77", dbg_data); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_wrap();
        test_partial();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
